int_ctrl_vec: RTL

Wishbone-slave vectored interrupt controller. It is the receiving end of the per-peripheral interrupt lines (`ext_int_o` of the external-interrupt block, timers, UART, NI, …). It edge-latches up to 32 request lines and masks them. It also prioritises them by fixed index (lower index = higher priority) and drives a single CPU interrupt. The CPU uses a claim/EOI register handshake, and nested preemption is supported.

---
 rtl/int_ctrl_pkg.sv | 10 +
 rtl/int_ctrl_vec_if.sv | 27 ++
 rtl/int_prio_enc.sv | 15 +
 rtl/int_ctrl_vec.sv | 83 ++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register map and claim constants for the vectored interrupt controller.
package int_ctrl_pkg;
   localparam logic [31:0] CTRL  = 32'd0;
   localparam logic [31:0] MASK  = 32'd1;
   localparam logic [31:0] PEND  = 32'd2;
   localparam logic [31:0] CLAIM = 32'd3;
   localparam logic [31:0] INSV  = 32'd4;
   localparam logic [31:0] RAW   = 32'd5;
   localparam int CLAIM_NONE = 0;
endpackage

// File: rtl/int_ctrl_vec_if.sv
// int_ctrl_vec_if: Wishbone slave bus bundle for the interrupt controller.
interface int_ctrl_vec_if #(
   parameter int Dw = 32,
   parameter int Aw = 3,
   parameter int SELw = 4,
   parameter int TAGw = 3
);
   logic [Dw-1:0] sa_dat_i;
   logic [SELw-1:0] sa_sel_i;
   logic [Aw-1:0] sa_addr_i;
   logic [TAGw-1:0] sa_tag_i;
   logic sa_stb_i;
   logic sa_cyc_i;
   logic sa_we_i;
   logic [Dw-1:0] sa_dat_o;
   logic sa_ack_o;
   logic sa_err_o;
   logic sa_rty_o;
   modport slave (
      input sa_dat_i, sa_sel_i, sa_addr_i, sa_tag_i, sa_stb_i, sa_cyc_i, sa_we_i,
      output sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
   );
   modport master (
      output sa_dat_i, sa_sel_i, sa_addr_i, sa_tag_i, sa_stb_i, sa_cyc_i, sa_we_i,
      input sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
   );
endinterface

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-set-index encoder; idx is N when nothing is set.
module int_prio_enc #(
   parameter int N = 8,
   localparam int W = $clog2(N + 1)
) (
   input logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic valid
);
   always_comb begin
      idx = W'(N);
      for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
   end
   assign valid = |req;
endmodule

// File: rtl/int_ctrl_vec.sv
// int_ctrl_vec: Wishbone vectored interrupt controller with edge latching,
// fixed-index priority, claim/EOI handshake and nested preemption.
module int_ctrl_vec
   import int_ctrl_pkg::*;
#(
   parameter int INT_NUM = 8,
   parameter int Aw = 3,
   parameter int SELw = 4,
   parameter int TAGw = 3,
   parameter int Dw = 32
) (
   input logic clk,
   input logic reset,
   int_ctrl_vec_if.slave wb,
   input logic [INT_NUM-1:0] int_i,
   output logic cpu_int_o
);
   localparam int BW = $clog2(INT_NUM + 1);
   logic [INT_NUM-1:0] s1, s2, s3, mask, pend, insv, cand, rise, claim_set, pend_clr, eoi_clr;
   logic ge, acc, wr, rd, eligible, best_valid, insv_valid, unused;
   logic [BW-1:0] best, top_insv;
   logic [Aw-1:0] addr;
   logic [SELw-1:0] sel;
   logic [TAGw-1:0] tag;
   logic [31:0] a;
   logic [Dw-1:0] rdata;
   assign addr = wb.sa_addr_i;
   assign sel = wb.sa_sel_i;
   assign tag = wb.sa_tag_i;
   assign unused = ^{sel, tag, insv_valid};
   assign a = 32'(addr);
   assign acc = wb.sa_stb_i & wb.sa_cyc_i & ~wb.sa_ack_o;
   assign wr = acc & wb.sa_we_i;
   assign rd = acc & ~wb.sa_we_i;
   assign rise = s2 & ~s3;
   assign cand = pend & mask;
   int_prio_enc #(.N(INT_NUM)) u_best (.req(cand), .idx(best), .valid(best_valid));
   int_prio_enc #(.N(INT_NUM)) u_top (.req(insv), .idx(top_insv), .valid(insv_valid));
   // an empty INSV encodes as INT_NUM, so any candidate beats it
   assign eligible = ge & best_valid & (best < top_insv);
   assign claim_set = (rd & (a == CLAIM) & eligible) ? INT_NUM'(1) << best : '0;
   assign pend_clr = (wr & (a == PEND)) ? wb.sa_dat_i[INT_NUM-1:0] : '0;
   always_comb begin
      eoi_clr = '0;
      for (int i = 0; i < INT_NUM; i++) eoi_clr[i] = wr & (a == CLAIM) & (wb.sa_dat_i == Dw'(i + 1));
   end
   always_comb begin
      rdata = a == CTRL  ? Dw'(ge) :
              a == MASK  ? Dw'(mask) :
              a == PEND  ? Dw'(pend) :
              a == CLAIM ? (eligible ? Dw'(best) + Dw'(1) : Dw'(CLAIM_NONE)) :
              a == INSV  ? Dw'(insv) :
              a == RAW   ? Dw'(s2) : '0;
   end
   assign wb.sa_err_o = 1'b0;
   assign wb.sa_rty_o = 1'b0;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
         ge <= 1'b0;
         mask <= '0;
         pend <= '0;
         insv <= '0;
         cpu_int_o <= 1'b0;
         wb.sa_ack_o <= 1'b0;
         wb.sa_dat_o <= '0;
      end else begin
         s1 <= int_i;
         s2 <= s1;
         s3 <= s2;
         if (wr & (a == CTRL)) ge <= wb.sa_dat_i[0];
         if (wr & (a == MASK)) mask <= wb.sa_dat_i[INT_NUM-1:0];
         // a fresh edge wins over a same-cycle clear
         pend <= (pend & ~(pend_clr | claim_set)) | rise;
         insv <= (insv | claim_set) & ~eoi_clr;
         cpu_int_o <= eligible;
         wb.sa_ack_o <= acc;
         wb.sa_dat_o <= rd ? rdata : '0;
      end
   end
endmodule
